// File: rtl/instr_encoder_if.sv
// ---------------------------------------------------------------------------
// instr_encoder_if
//   Request/stream bundle for the instruction encoder.
//   Request side : in_valid/in_ready handshake carrying kind plus the
//                  register, shift, immediate and jump-target fields.
//   Stream side  : out_valid/out_ready handshake carrying the encoded word
//                  and its word address, plus the emitted-word count and the
//                  sticky illegal-kind flag.
//   Modports     : master = request producer / stream consumer,
//                  slave  = the encoder.
// ---------------------------------------------------------------------------
interface instr_encoder_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic              in_ready;
   logic [3:0]        in_kind;
   logic [4:0]        in_rs;
   logic [4:0]        in_rt;
   logic [4:0]        in_rd;
   logic [4:0]        in_shamt;
   logic [15:0]       in_imm;
   logic [25:0]       in_target;
   logic              out_valid;
   logic              out_ready;
   logic [31:0]       out_word;
   logic [ADDR_W-1:0] out_addr;
   logic [ADDR_W:0]   count;
   logic              err;

   modport master (
      output in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
      output out_ready,
      input  in_ready, out_valid, out_word, out_addr, count, err
   );

   modport slave (
      input  in_valid, in_kind, in_rs, in_rt, in_rd, in_shamt, in_imm, in_target,
      input  out_ready,
      output in_ready, out_valid, out_word, out_addr, count, err
   );
endinterface

// File: rtl/instr_encoder.sv
// ---------------------------------------------------------------------------
// instr_encoder
//   Packs symbolic instruction requests into 32-bit MIPS words (addu, subu,
//   ori, lw, sw, beq, lui, sll, jal, jr), buffers them in a DEPTH-entry FIFO
//   and streams them out with an incrementing word address.
//
//   Ports:
//     clk    - clock, all state changes on the rising edge
//     reset  - asynchronous, active-high; flushes FIFO, clears address,
//              count, error flag and padding state
//     bus    - instr_encoder_if.slave (request handshake in, word stream out)
//
//   Optional feature (macro ENC_NOP_PAD_EN):
//     When defined, every accepted beq/jal/jr is followed in the stream by a
//     delay-slot nop (0x00000000) pushed from a PAD state. The nop takes an
//     address and counts like any other word. When undefined, exactly one
//     word is emitted per legal request.
// ---------------------------------------------------------------------------
module instr_encoder #(
   parameter int DEPTH     = 4,
   parameter int ADDR_W    = 10,
   parameter int BASE_ADDR = 0
) (
   input logic             clk,
   input logic             reset,
   instr_encoder_if.slave  bus
);
   localparam int PTR_W = $clog2(DEPTH);

   logic [31:0]       fifoMem [DEPTH];
   logic [PTR_W-1:0]  wrPtr;
   logic [PTR_W-1:0]  rdPtr;
   logic [PTR_W:0]    occupancy;
   logic              fifoFull;
   logic              fifoEmpty;

   logic [ADDR_W-1:0] addrPtr;
   logic [ADDR_W:0]   emitCount;
   logic              errFlag;

   logic              acceptOpen;
   logic              accept;
   logic              kindLegal;
   logic              padPush;
   logic              push;
   logic              pop;
   logic [31:0]       encWord;
   logic [31:0]       pushWord;

   assign fifoFull  = (occupancy == (PTR_W+1)'(DEPTH));
   assign fifoEmpty = (occupancy == '0);

   // in_ready looks only at registered occupancy and state.
   assign bus.in_ready = !fifoFull && acceptOpen;
   assign accept       = bus.in_valid && bus.in_ready;
   assign kindLegal    = (bus.in_kind <= 4'd9);

   assign pop  = !fifoEmpty && bus.out_ready;
   // accept and padPush never coincide: in_ready is low while padding.
   assign push     = (accept && kindLegal) || padPush;
   assign pushWord = padPush ? 32'h0000_0000 : encWord;

   // Field packing; fields absent from a format are simply not used.
   always_comb begin
      encWord = 32'h0000_0000;
      case (bus.in_kind)
         4'd0: encWord = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h21};
         4'd1: encWord = {6'h00, bus.in_rs, bus.in_rt, bus.in_rd, 5'b0, 6'h23};
         4'd2: encWord = {6'h0d, bus.in_rs, bus.in_rt, bus.in_imm};
         4'd3: encWord = {6'h23, bus.in_rs, bus.in_rt, bus.in_imm};
         4'd4: encWord = {6'h2b, bus.in_rs, bus.in_rt, bus.in_imm};
         4'd5: encWord = {6'h04, bus.in_rs, bus.in_rt, bus.in_imm};
         4'd6: encWord = {6'h0f, 5'b0, bus.in_rt, bus.in_imm};
         4'd7: encWord = {6'h00, 5'b0, bus.in_rt, bus.in_rd, bus.in_shamt, 6'h00};
         4'd8: encWord = {6'h03, bus.in_target};
         4'd9: encWord = {6'h00, bus.in_rs, 15'b0, 6'h08};
         default: encWord = 32'h0000_0000;
      endcase
   end

`ifdef ENC_NOP_PAD_EN
   typedef enum logic {ACCEPT, PAD} encState_t;
   encState_t state;
   encState_t stateNext;
   logic      isBranch;

   assign isBranch   = (bus.in_kind == 4'd5) || (bus.in_kind == 4'd8) ||
                       (bus.in_kind == 4'd9);
   assign acceptOpen = (state == ACCEPT);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) state <= ACCEPT;
      else       state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      padPush   = 1'b0;
      case (state)
         ACCEPT: if (accept && isBranch) stateNext = PAD;
         PAD: begin
            // Wait for a free slot; a same-cycle pop does not count.
            if (!fifoFull) begin
               padPush   = 1'b1;
               stateNext = ACCEPT;
            end
         end
         default: stateNext = ACCEPT;
      endcase
   end
`else
   assign acceptOpen = 1'b1;
   assign padPush    = 1'b0;
`endif

   // Storage carries no reset; emptiness is tracked by the pointers and the
   // head is masked to zero when the FIFO is empty.
   always_ff @(posedge clk) begin
      if (push) fifoMem[wrPtr] <= pushWord;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         wrPtr     <= '0;
         rdPtr     <= '0;
         occupancy <= '0;
         addrPtr   <= ADDR_W'(BASE_ADDR);
         emitCount <= '0;
         errFlag   <= 1'b0;
      end else begin
         if (push) wrPtr <= wrPtr + 1'b1;
         if (pop) begin
            rdPtr   <= rdPtr + 1'b1;
            addrPtr <= addrPtr + 1'b1;
            if (emitCount != {(ADDR_W+1){1'b1}}) emitCount <= emitCount + 1'b1;
         end
         case ({push, pop})
            2'b10:   occupancy <= occupancy + 1'b1;
            2'b01:   occupancy <= occupancy - 1'b1;
            default: occupancy <= occupancy;
         endcase
         if (accept && !kindLegal) errFlag <= 1'b1;
      end
   end

   assign bus.out_valid = !fifoEmpty;
   assign bus.out_word  = fifoEmpty ? 32'h0000_0000 : fifoMem[rdPtr];
   assign bus.out_addr  = addrPtr;
   assign bus.count     = emitCount;
   assign bus.err       = errFlag;
endmodule

// File: tb/tb_instr_encoder.sv
// ---------------------------------------------------------------------------
// tb_instr_encoder
//   Scoreboard bench for instr_encoder (DEPTH=4, ADDR_W=2, BASE_ADDR=0).
//   The driver pushes expected words into a queue when a request is
//   accepted; a monitor compares the stream, address, count, err and
//   in_ready every cycle against that queue.
// ---------------------------------------------------------------------------
module tb_instr_encoder;
   localparam int DEPTH  = 4;
   localparam int ADDR_W = 2;
   localparam int ASPAN  = 1 << ADDR_W;
   localparam int MAXC   = (1 << (ADDR_W + 1)) - 1;

   logic clk;
   logic reset;

   instr_encoder_if #(.ADDR_W(ADDR_W)) bus ();

   instr_encoder #(.DEPTH(DEPTH), .ADDR_W(ADDR_W), .BASE_ADDR(0)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // scoreboard state
   logic [31:0] expQ[$];
   int          expAddr  = 0;
   int          expCount = 0;
   bit          expErr   = 0;
   bit          padOwed  = 0;
   int          nChecks  = 0;
   int          nPass    = 0;
   bit          randReady = 0;
   bit          readyForce = 0;

`ifdef ENC_NOP_PAD_EN
   localparam bit PAD_EN = 1'b1;
`else
   localparam bit PAD_EN = 1'b0;
`endif

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act === exp) nPass++;
      else $display("FAIL %s: got 0x%08h, expected 0x%08h at %0t", nm, act, exp, $time);
   endtask

   // Reference encoder: opcode and fields placed by weight.
   function automatic logic [31:0] refEncode(input int kind, input int rs, input int rt,
                                             input int rd, input int sh, input int imm,
                                             input int tgt);
      longint w;
      longint op26 = 64'd1 << 26;
      longint rs21 = longint'(rs) * (64'd1 << 21);
      longint rt16 = longint'(rt) * (64'd1 << 16);
      longint rd11 = longint'(rd) * (64'd1 << 11);
      w = 0;
      case (kind)
         0: w = rs21 + rt16 + rd11 + 33;
         1: w = rs21 + rt16 + rd11 + 35;
         2: w = 13 * op26 + rs21 + rt16 + imm;
         3: w = 35 * op26 + rs21 + rt16 + imm;
         4: w = 43 * op26 + rs21 + rt16 + imm;
         5: w = 4 * op26 + rs21 + rt16 + imm;
         6: w = 15 * op26 + rt16 + imm;
         7: w = rt16 + rd11 + longint'(sh) * 64 + 0;
         8: w = 3 * op26 + tgt;
         9: w = rs21 + 8;
         default: w = 0;
      endcase
      return w[31:0];
   endfunction

   // out_ready driver: changes just after the rising edge only.
   initial begin
      bus.out_ready = 1'b0;
      forever begin
         @(posedge clk);
         #1;
         bus.out_ready = randReady ? 1'($urandom_range(0, 1)) : readyForce;
      end
   end

   task automatic send(input int kind, input int rs, input int rt, input int rd,
                       input int sh, input int imm, input int tgt, output int waited);
      bit ok = 0;
      waited = 0;
      bus.in_kind   = 4'(kind);
      bus.in_rs     = 5'(rs);
      bus.in_rt     = 5'(rt);
      bus.in_rd     = 5'(rd);
      bus.in_shamt  = 5'(sh);
      bus.in_imm    = 16'(imm);
      bus.in_target = 26'(tgt);
      bus.in_valid  = 1'b1;
      for (int i = 0; i < 200; i++) begin
         @(negedge clk);
         if (bus.in_ready) begin
            ok = 1;
            break;
         end
         waited++;
      end
      if (!ok) begin
         nChecks++;
         $display("FAIL accept_timeout: kind %0d never accepted within 200 cycles", kind);
         bus.in_valid = 1'b0;
         return;
      end
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      if (kind <= 9) expQ.push_back(refEncode(kind, rs, rt, rd, sh, imm, tgt));
      else expErr = 1;
      if (PAD_EN && (kind == 5 || kind == 8 || kind == 9)) padOwed = 1;
      $display("accept kind=%0d rs=%0d rt=%0d rd=%0d sh=%0d imm=0x%04h tgt=0x%07h wait=%0d",
               kind, rs, rt, rd, sh, imm, tgt, waited);
   endtask

   task automatic waitDrain(input string nm);
      bit ok = 0;
      for (int i = 0; i < 300; i++) begin
         @(negedge clk);
         if (expQ.size() == 0 && !padOwed && !bus.out_valid) begin
            ok = 1;
            break;
         end
      end
      if (!ok) begin
         nChecks++;
         $display("FAIL %s: stream not drained, %0d words still expected", nm, expQ.size());
      end
      @(posedge clk);
      #1;
   endtask

   // Monitor: every falling edge compares handshake state against the model.
   initial begin
      int sz;
      bit fire;
      bit padDue;
      forever begin
         @(negedge clk);
         sz = expQ.size();
         chk("in_ready", 32'(bus.in_ready), 32'(!padOwed && sz < DEPTH));
         chk("out_valid", 32'(bus.out_valid), 32'(sz != 0));
         chk("count", 32'(bus.count), 32'(expCount));
         chk("err", 32'(bus.err), 32'(expErr));
         fire   = 0;
         padDue = padOwed && (sz < DEPTH);
         if (bus.out_valid && bus.out_ready) begin
            if (sz == 0) begin
               nChecks++;
               $display("FAIL unexpected_word: got 0x%08h, expected no output", bus.out_word);
            end else begin
               chk("word", bus.out_word, expQ[0]);
               chk("addr", 32'(bus.out_addr), 32'(expAddr));
               $display("emit addr=%0d word=0x%08h expected=0x%08h count=%0d",
                        bus.out_addr, bus.out_word, expQ[0], bus.count);
               fire = 1;
            end
         end else if (!bus.out_valid) begin
            chk("idle_word", bus.out_word, 32'h0);
         end
         @(posedge clk);
         if (fire) begin
            void'(expQ.pop_front());
            expAddr = (expAddr + 1) % ASPAN;
            if (expCount < MAXC) expCount++;
         end
         if (padDue) begin
            expQ.push_back(32'h0);
            padOwed = 0;
         end
      end
   end

   initial begin
      #400000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int w;
      reset         = 1'b1;
      bus.in_valid  = 1'b0;
      bus.in_kind   = '0;
      bus.in_rs     = '0;
      bus.in_rt     = '0;
      bus.in_rd     = '0;
      bus.in_shamt  = '0;
      bus.in_imm    = '0;
      bus.in_target = '0;
      repeat (3) @(posedge clk);
      #3 reset = 1'b0;
      @(posedge clk);
      #1;
      chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("reset_out_word", bus.out_word, 32'd0);
      chk("reset_out_addr", 32'(bus.out_addr), 32'd0);
      chk("reset_count", 32'(bus.count), 32'd0);
      chk("reset_in_ready", 32'(bus.in_ready), 32'd1);

      // ori with the stream stalled: visible the cycle after acceptance
      send(2, 0, 1, 0, 0, 'h3456, 0, w);
      chk("ori_valid_next", 32'(bus.out_valid), 32'd1);
      chk("ori_head", bus.out_word, 32'h3401_3456);
      send(0, 1, 1, 1, 5, 0, 0, w);          // addu, shamt ignored
      send(7, 3, 8, 8, 2, 0, 0, w);          // sll, rs ignored
      send(4, 2, 3, 0, 0, 'hfffc, 0, w);     // sw
      chk("full_in_ready", 32'(bus.in_ready), 32'd0);
      readyForce = 1;
      send(3, 29, 31, 0, 0, 'h0010, 0, w);   // lw waits for space
      waitDrain("drain_fill");

      // illegal kind: completes, sets err, emits nothing
      send(12, 1, 2, 3, 4, 'h1234, 0, w);
      chk("illegal_err", 32'(bus.err), 32'd1);
      chk("illegal_no_valid", 32'(bus.out_valid), 32'd0);
      chk("illegal_count", 32'(bus.count), 32'(expCount));
      send(6, 0, 2, 0, 0, 'h7878, 0, w);     // lui
      chk("lui_head", bus.out_word, 32'h3c02_7878);
      waitDrain("drain_lui");

      // jal: delay-slot nop only when padding is built in
      send(8, 0, 0, 0, 0, 'hc22, 'hc22, w);
`ifdef ENC_NOP_PAD_EN
      chk("jal_pad_in_ready", 32'(bus.in_ready), 32'd0);
      send(2, 4, 5, 0, 0, 'h0001, 0, w);
      chk("jal_pad_wait", 32'(w), 32'd1);
`else
      chk("jal_in_ready", 32'(bus.in_ready), 32'd1);
      send(2, 4, 5, 0, 0, 'h0001, 0, w);
      chk("jal_b2b_wait", 32'(w), 32'd0);
`endif
      waitDrain("drain_jal");

      // mid-stream reset with three words queued
      readyForce = 0;
      @(posedge clk);
      #1;
      send(1, 7, 8, 9, 0, 0, 0, w);
      send(2, 1, 1, 0, 0, 'h00ff, 0, w);
      send(9, 31, 0, 0, 0, 0, 0, w);
      @(posedge clk);
      #3 reset = 1'b1;
      expQ.delete();
      expAddr  = 0;
      expCount = 0;
      expErr   = 0;
      padOwed  = 0;
      #1;
      chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midreset_out_addr", 32'(bus.out_addr), 32'd0);
      chk("midreset_count", 32'(bus.count), 32'd0);
      chk("midreset_err", 32'(bus.err), 32'd0);
      @(posedge clk);
      #3 reset = 1'b0;
      readyForce = 1;

      // five words through a 2-bit address: wraps 3 -> 0
      for (int i = 0; i < 5; i++)
         send(int'($urandom_range(0, 9)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 67108863)), w);
      waitDrain("drain_wrap");
      chk("wrap_out_addr", 32'(bus.out_addr), 32'(expAddr));

      // randomized traffic with a random consumer; count saturates
      randReady = 1;
      for (int i = 0; i < 60; i++)
         send(int'($urandom_range(0, 15)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 31)),
              int'($urandom_range(0, 31)), int'($urandom_range(0, 65535)),
              int'($urandom_range(0, 67108863)), w);
      randReady = 0;
      readyForce = 1;
      waitDrain("drain_random");
      chk("final_count", 32'(bus.count), 32'(expCount));
      chk("final_queue_empty", 32'(expQ.size()), 32'd0);

      $display("%0d/%0d checks passed", nPass, nChecks);
      $finish;
   end
endmodule
